// File: rtl/timer_periph.sv
// timer_periph: memory-mapped down-counting timer with prescaler, auto-reload and level irq
module timer_periph #(
  parameter int PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        rd_clr,
  output logic [31:0] timer_rdata,
  output logic        irq
);
  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic auto_q, auto_d, done_q, done_d;
  logic [29:0] count_q, count_d, reload_q, reload_d;
  logic [PSW-1:0] ps_q, ps_d;
  logic tick;
  assign tick = (state_q == RUN) && (ps_q == PSW'(PRESCALE - 1));
  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    done_d   = done_q & ~rd_clr;
    count_d  = count_q;
    reload_d = reload_q;
    ps_d     = ps_q;
    if (we) begin
      reload_d = wdata[29:0];
      count_d  = wdata[29:0];
      ps_d     = '0;
      auto_d   = wdata[30];
      done_d   = 1'b0;
      state_d  = (wdata[31] && wdata[29:0] != '0) ? RUN : IDLE;
    end else if (state_q == RUN) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
      // expiry sets done even when rd_clr lands in the same cycle
      if (tick && count_q == 30'd1) begin
        done_d  = 1'b1;
        count_d = auto_q ? reload_q : '0;
        state_d = auto_q ? RUN : IDLE;
      end else if (tick && count_q != '0) begin
        count_d = count_q - 30'd1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      auto_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      reload_q <= '0;
      ps_q     <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      done_q   <= done_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      ps_q     <= ps_d;
    end
  end
  assign timer_rdata = {state_q == RUN, done_q, count_q};
  assign irq         = done_q;
endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed and randomized checks of timer_periph against an elapsed-time model
module tb_timer_periph;
  localparam int P = 4;
  logic clk = 1'b0, rst = 1'b1, we = 1'b0, rd_clr = 1'b0;
  logic [31:0] wdata = '0, timer_rdata;
  logic irq;
  int n_chk = 0, n_pass = 0;
  longint cyc = 0, m_wcyc = 0;
  logic m_en = 1'b0, m_auto = 1'b0, m_done = 1'b0;
  longint m_load = 0;

  timer_periph #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .we(we), .wdata(wdata), .rd_clr(rd_clr),
    .timer_rdata(timer_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Expected word derived from time elapsed since the last write
  function automatic logic [31:0] model_word();
    longint el = cyc - m_wcyc, lp = m_load * P, ticks, cnt;
    logic run;
    ticks = el / P;
    run = m_en && (m_auto || el < lp);
    if (!m_en) cnt = m_load;
    else if (m_auto) cnt = m_load - (ticks % m_load);
    else cnt = (ticks >= m_load) ? 0 : m_load - ticks;
    return {run, m_done, 30'(cnt)};
  endfunction

  task automatic model_reset();
    m_en = 1'b0; m_auto = 1'b0; m_done = 1'b0; m_load = 0; m_wcyc = cyc;
  endtask

  task automatic step(input logic w, input logic [31:0] d, input logic c);
    longint el, lp;
    logic expire;
    @(negedge clk);
    we = w; wdata = d; rd_clr = c;
    @(posedge clk);
    cyc++;
    if (w) begin
      m_load = longint'(d[29:0]);
      m_en = d[31] && m_load != 0;
      m_auto = d[30];
      m_wcyc = cyc;
      m_done = 1'b0;
    end else begin
      el = cyc - m_wcyc;
      lp = m_load * P;
      expire = m_en && el % lp == 0 && (m_auto || el == lp);
      m_done = expire ? 1'b1 : (c ? 1'b0 : m_done);
    end
    #1;
    chk("rdata_model", timer_rdata, model_word());
    chk("irq_model", {31'b0, irq}, {31'b0, m_done});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rdata", timer_rdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", timer_rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h8000_0003, 1'b0);
    chk("os_load", timer_rdata, 32'h8000_0003);
    idle(4);
    chk("os_k4", timer_rdata, 32'h8000_0002);
    idle(4);
    chk("os_k8", timer_rdata, 32'h8000_0001);
    idle(4);
    chk("os_expire", timer_rdata, 32'h4000_0000);
    chk("os_irq", {31'b0, irq}, 32'h1);
    step(1'b0, 32'h0, 1'b1);
    chk("clr_rdata", timer_rdata, 32'h0);
    idle(5);
    chk("clr_stays", timer_rdata, 32'h0);
    step(1'b1, 32'hC000_0002, 1'b0);
    idle(8);
    chk("auto_first", timer_rdata, 32'hC000_0002);
    step(1'b0, 32'h0, 1'b1);
    chk("auto_clr", timer_rdata, 32'h8000_0002);
    idle(7);
    chk("auto_second", timer_rdata, 32'hC000_0002);
    step(1'b0, 32'h0, 1'b1);
    idle(6);
    chk("auto_pre_third", {31'b0, irq}, 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("expiry_beats_clr", timer_rdata, 32'hC000_0002);
    chk("expiry_beats_clr_irq", {31'b0, irq}, 32'h1);
    idle(3);
    mid_reset();
    idle(2);
    step(1'b1, 32'h8000_0000, 1'b0);
    chk("zero_load", timer_rdata, 32'h0);
    idle(20);
    chk("zero_load_irq", {31'b0, irq}, 32'h0);
    step(1'b1, 32'h8000_0007, 1'b0);
    idle(3);
    step(1'b1, 32'h8000_0005, 1'b0);
    chk("write_on_tick", timer_rdata, 32'h8000_0005);
    idle(3);
    chk("ps_restart", timer_rdata, 32'h8000_0005);
    idle(1);
    chk("ps_restart_tick", timer_rdata, 32'h8000_0004);
    step(1'b1, 32'h0000_0009, 1'b0);
    idle(10);
    chk("en0_hold", timer_rdata, 32'h0000_0009);
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[29:0] = 30'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) mid_reset();
      else step($urandom_range(0, 15) == 0, d, $urandom_range(0, 5) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
